// File: rtl/fft_peak_tracker.sv
// fft_peak_tracker
//   Per FFT frame, computes |X[k]|^2 for every streamed bin and tracks the strongest
//   bin in MIN_BIN..FFT_SIZE/2-1. At frame end the peak (bin + magnitude) is placed
//   in a single-entry output slot with a valid/ready handshake.
// Ports
//   clk_in, rst_in              clock, asynchronous active-high reset
//   fft_tdata/tvalid/tlast      FFT output stream {imag, real}, signed components
//   fft_tready                  always 1, the FFT cannot be stalled
//   peak_valid_out/ready_in     result handshake
//   peak_bin_out, peak_mag_out  peak bin (0 = below MAG_THRESH) and its |X|^2
//   frame_count_out             accepted results, wraps
//   frame_err_out, overrun_out  sticky error flags
module fft_peak_tracker #(
    parameter int FFT_SIZE   = 1024,
    parameter int DATA_W     = 16,
    parameter int MIN_BIN    = 2,
    parameter int MAG_THRESH = 4096
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [2*DATA_W-1:0] fft_tdata,
    input  logic                fft_tvalid,
    input  logic                fft_tlast,
    output logic                fft_tready,
    output logic                peak_valid_out,
    input  logic                peak_ready_in,
    output logic [31:0]         peak_bin_out,
    output logic [2*DATA_W:0]   peak_mag_out,
    output logic [15:0]         frame_count_out,
    output logic                frame_err_out,
    output logic                overrun_out
);
    localparam int BW    = $clog2(FFT_SIZE);
    localparam int PW    = 2 * DATA_W;
    localparam int MAG_W = 2 * DATA_W + 1;
    localparam logic [BW-1:0]    LAST_BIN = BW'(FFT_SIZE - 1);
    localparam logic [BW-1:0]    HALF_BIN = BW'(FFT_SIZE / 2);
    localparam logic [BW-1:0]    LOW_BIN  = BW'(MIN_BIN);
    localparam logic [MAG_W-1:0] THRESH   = MAG_W'(MAG_THRESH);

    logic [BW-1:0]            bin_cnt_q;
    logic signed [DATA_W-1:0] s1_re_q, s1_im_q;
    logic [BW-1:0]            s1_bin_q, s2_bin_q, s3_bin_q;
    logic [PW-1:0]            s2_pre_q, s2_pim_q;
    logic [MAG_W-1:0]         s3_mag_q;
    // Per-stage tags: beat valid, good frame end, length error.
    logic [3:1]               vld_pipe_q, last_pipe_q, err_pipe_q;
    logic [MAG_W-1:0]         max_mag_q;
    logic [BW-1:0]            max_bin_q;
    logic                     out_vld_q;
    logic [BW-1:0]            out_bin_q;
    logic [MAG_W-1:0]         out_mag_q;
    logic [15:0]              cnt_q;
    logic                     ferr_q, ovr_q;

    logic                     at_end, beat_err;
    logic signed [PW-1:0]     re_ext, im_ext;
    logic                     hit, res_new, frame_end, xfer;
    logic [MAG_W-1:0]         cand_mag_d;
    logic [BW-1:0]            cand_bin_d;

    assign at_end   = (bin_cnt_q == LAST_BIN);
    // Length error: tlast off the last bin, or last bin reached without tlast.
    assign beat_err = fft_tlast != at_end;
    assign re_ext   = PW'(s1_re_q);
    assign im_ext   = PW'(s1_im_q);
    assign xfer     = out_vld_q && peak_ready_in;

    always_comb begin
        hit        = vld_pipe_q[3] && (s3_bin_q >= LOW_BIN) && (s3_bin_q < HALF_BIN)
                     && (s3_mag_q > max_mag_q);
        cand_mag_d = hit ? s3_mag_q : max_mag_q;
        cand_bin_d = hit ? s3_bin_q : max_bin_q;
        res_new    = vld_pipe_q[3] && last_pipe_q[3];
        frame_end  = vld_pipe_q[3] && (last_pipe_q[3] || err_pipe_q[3]);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            bin_cnt_q   <= '0;
            s1_re_q     <= '0;
            s1_im_q     <= '0;
            s1_bin_q    <= '0;
            s2_bin_q    <= '0;
            s3_bin_q    <= '0;
            s2_pre_q    <= '0;
            s2_pim_q    <= '0;
            s3_mag_q    <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            err_pipe_q  <= '0;
            max_mag_q   <= '0;
            max_bin_q   <= '0;
            out_vld_q   <= 1'b0;
            out_bin_q   <= '0;
            out_mag_q   <= '0;
            cnt_q       <= '0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            if (fft_tvalid) begin
                bin_cnt_q <= (fft_tlast || at_end) ? '0 : bin_cnt_q + 1'b1;
                if (beat_err) ferr_q <= 1'b1;
            end
            // S1: capture
            s1_re_q        <= fft_tdata[DATA_W-1:0];
            s1_im_q        <= fft_tdata[2*DATA_W-1:DATA_W];
            s1_bin_q       <= bin_cnt_q;
            vld_pipe_q[1]  <= fft_tvalid;
            last_pipe_q[1] <= fft_tlast && at_end;
            err_pipe_q[1]  <= beat_err;
            // S2: squares (always non-negative, so stored unsigned)
            s2_pre_q       <= re_ext * re_ext;
            s2_pim_q       <= im_ext * im_ext;
            s2_bin_q       <= s1_bin_q;
            // S3: magnitude, one extra bit absorbs the carry
            s3_mag_q       <= {1'b0, s2_pre_q} + {1'b0, s2_pim_q};
            s3_bin_q       <= s2_bin_q;
            vld_pipe_q[3:2]  <= vld_pipe_q[2:1];
            last_pipe_q[3:2] <= last_pipe_q[2:1];
            err_pipe_q[3:2]  <= err_pipe_q[2:1];
            // S4: running max; frame end clears it so the next frame's
            // first compare (next cycle) starts from zero.
            if (frame_end) begin
                max_mag_q <= '0;
                max_bin_q <= '0;
            end else if (hit) begin
                max_mag_q <= cand_mag_d;
                max_bin_q <= cand_bin_d;
            end
            // Output slot
            if (xfer) cnt_q <= cnt_q + 16'd1;
            if (res_new) begin
                if (!out_vld_q || xfer) begin
                    out_vld_q <= 1'b1;
                    out_bin_q <= (cand_mag_d < THRESH) ? '0 : cand_bin_d;
                    out_mag_q <= cand_mag_d;
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (xfer) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign fft_tready      = 1'b1;
    assign peak_valid_out  = out_vld_q;
    assign peak_bin_out    = {{(32-BW){1'b0}}, out_bin_q};
    assign peak_mag_out    = out_mag_q;
    assign frame_count_out = cnt_q;
    assign frame_err_out   = ferr_q;
    assign overrun_out     = ovr_q;
endmodule

// File: tb/tb_fft_peak_tracker.sv
module tb_fft_peak_tracker;
    localparam int N  = 1024;
    localparam int DW = 16;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [2*DW-1:0] fft_tdata;
    logic          fft_tvalid, fft_tlast, fft_tready;
    logic          peak_valid_out, peak_ready_in;
    logic [31:0]   peak_bin_out;
    logic [2*DW:0] peak_mag_out;
    logic [15:0]   frame_count_out;
    logic          frame_err_out, overrun_out;

    fft_peak_tracker #(.FFT_SIZE(N), .DATA_W(DW), .MIN_BIN(2), .MAG_THRESH(4096)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .fft_tdata(fft_tdata), .fft_tvalid(fft_tvalid),
        .fft_tlast(fft_tlast), .fft_tready(fft_tready), .peak_valid_out(peak_valid_out),
        .peak_ready_in(peak_ready_in), .peak_bin_out(peak_bin_out), .peak_mag_out(peak_mag_out),
        .frame_count_out(frame_count_out), .frame_err_out(frame_err_out),
        .overrun_out(overrun_out));

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int fre[N];
    int fim[N];
    longint got_bin[$];
    longint got_mag[$];
    longint exp_bin[$];
    longint exp_mag[$];

    // Record every accepted result (sampled mid-cycle, transfer happens at next edge).
    always @(negedge clk_in)
        if (!rst_in && peak_valid_out && peak_ready_in) begin
            got_bin.push_back(longint'(peak_bin_out));
            got_mag.push_back(longint'(peak_mag_out));
        end

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int re, input int im);
        for (int i = 0; i < N; i++) begin
            fre[i] = re;
            fim[i] = im;
        end
    endtask

    // Reference: strongest bin in the lower half from MIN_BIN, first wins ties.
    task automatic model(output longint b, output longint m);
        longint best = 0;
        longint bb = 0;
        for (int k = 2; k < N / 2; k++) begin
            longint p = longint'(fre[k]) * fre[k] + longint'(fim[k]) * fim[k];
            if (p > best) begin
                best = p;
                bb = k;
            end
        end
        m = best;
        b = (best < 4096) ? 0 : bb;
    endtask

    task automatic send_frame(input int len, input bit tl);
        for (int i = 0; i < len; i++) begin
            fft_tdata  = {fim[i][DW-1:0], fre[i][DW-1:0]};
            fft_tvalid = 1'b1;
            fft_tlast  = tl && (i == len - 1);
            @(posedge clk_in); #1;
        end
        fft_tvalid = 1'b0;
        fft_tlast  = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk_in); #1; end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!peak_valid_out && n < 12) begin
            @(posedge clk_in); #1;
            n++;
        end
        chk(tag, longint'(peak_valid_out), 1);
    endtask

    longint mb, mm;

    initial begin
        rst_in = 1'b1;
        fft_tdata = '0;
        fft_tvalid = 1'b0;
        fft_tlast = 1'b0;
        peak_ready_in = 1'b1;
        cycles(2);
        chk("rst_valid", longint'(peak_valid_out), 0);
        chk("rst_bin", longint'(peak_bin_out), 0);
        chk("rst_mag", longint'(peak_mag_out), 0);
        chk("rst_count", longint'(frame_count_out), 0);
        chk("rst_err", longint'(frame_err_out), 0);
        chk("rst_ovr", longint'(overrun_out), 0);
        chk("rst_tready", longint'(fft_tready), 1);
        rst_in = 1'b0;
        cycles(1);

        // Tone with exact latency check
        fill(1, 1);
        fre[37] = 1000; fim[37] = 0;
        model(mb, mm);
        send_frame(N, 1'b1);
        cycles(2);
        chk("tone_early", longint'(peak_valid_out), 0);
        cycles(1);
        chk("tone_valid", longint'(peak_valid_out), 1);
        chk("tone_bin", longint'(peak_bin_out), 37);
        chk("tone_mag", longint'(peak_mag_out), 1000000);
        chk("tone_model", longint'(peak_bin_out), mb);
        cycles(1);
        chk("tone_count", longint'(frame_count_out), 1);
        chk("tone_drop", longint'(peak_valid_out), 0);

        // Ties and excluded bins
        fill(0, 0);
        fre[1] = 500; fim[1] = 500; fre[5] = 500; fim[5] = 500;
        fre[9] = 500; fim[9] = 500; fre[600] = 500; fim[600] = 500;
        send_frame(N, 1'b1);
        wait_valid("tie_valid");
        chk("tie_bin", longint'(peak_bin_out), 5);
        chk("tie_mag", longint'(peak_mag_out), 500000);
        cycles(1);
        chk("tie_count", longint'(frame_count_out), 2);

        // Silence under threshold
        fill(10, -10);
        send_frame(N, 1'b1);
        wait_valid("sil_valid");
        chk("sil_bin", longint'(peak_bin_out), 0);
        chk("sil_mag", longint'(peak_mag_out), 200);
        cycles(1);

        // Stall across two back-to-back frames
        peak_ready_in = 1'b0;
        fill(0, 0); fre[20] = 3000;
        send_frame(N, 1'b1);
        fill(0, 0); fre[40] = 3000;
        send_frame(N, 1'b1);
        cycles(6);
        chk("stall_valid", longint'(peak_valid_out), 1);
        chk("stall_bin", longint'(peak_bin_out), 20);
        chk("stall_ovr", longint'(overrun_out), 1);
        chk("stall_count", longint'(frame_count_out), 3);
        peak_ready_in = 1'b1;
        cycles(1);
        chk("stall_xfer", longint'(frame_count_out), 4);
        cycles(4);
        chk("stall_once", longint'(peak_valid_out), 0);

        // Early tlast, then a clean frame
        fill(0, 0); fre[100] = 3000;
        send_frame(512, 1'b1);
        cycles(8);
        chk("bad_novalid", longint'(peak_valid_out), 0);
        chk("bad_err", longint'(frame_err_out), 1);
        fill(0, 0); fre[77] = 2000;
        send_frame(N, 1'b1);
        wait_valid("bad_next_valid");
        chk("bad_next_bin", longint'(peak_bin_out), 77);
        chk("bad_next_mag", longint'(peak_mag_out), 4000000);
        cycles(1);

        // Reset mid-frame
        fill(0, 0); fre[200] = 3000;
        send_frame(300, 1'b0);
        rst_in = 1'b1;
        #1;
        chk("mrst_err", longint'(frame_err_out), 0);
        chk("mrst_ovr", longint'(overrun_out), 0);
        chk("mrst_count", longint'(frame_count_out), 0);
        chk("mrst_valid", longint'(peak_valid_out), 0);
        chk("mrst_tready", longint'(fft_tready), 1);
        cycles(1);
        rst_in = 1'b0;
        fill(0, 0); fre[300] = 2500;
        send_frame(N, 1'b1);
        wait_valid("mrst_next_valid");
        chk("mrst_next_bin", longint'(peak_bin_out), 300);
        cycles(1);
        chk("mrst_next_count", longint'(frame_count_out), 1);

        // Random back-to-back frames against the model
        got_bin.delete();
        got_mag.delete();
        for (int f = 0; f < 5; f++) begin
            int amp = (f % 2 == 0) ? 40 : 100;
            for (int i = 0; i < N; i++) begin
                fre[i] = int'($urandom_range(2 * amp)) - amp;
                fim[i] = int'($urandom_range(2 * amp)) - amp;
            end
            if (f == 3) fre[int'($urandom_range(N - 1))] = 5000;
            model(mb, mm);
            exp_bin.push_back(mb);
            exp_mag.push_back(mm);
            send_frame(N, 1'b1);
        end
        cycles(10);
        chk("rand_n", longint'(got_bin.size()), longint'(exp_bin.size()));
        for (int f = 0; f < exp_bin.size() && f < got_bin.size(); f++) begin
            chk($sformatf("rand_bin%0d", f), got_bin[f], exp_bin[f]);
            chk($sformatf("rand_mag%0d", f), got_mag[f], exp_mag[f]);
        end
        chk("rand_count", longint'(frame_count_out), 6);
        chk("rand_err", longint'(frame_err_out), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
